// File: rtl/subinst_collect5.sv
// Five-to-one round-robin collector with a tagged FIFO on the upward path of a hierarchy level.
// Define COLLECT5_STATS_EN to add the saturating delivered-word counter on port stat_cnt.
module subinst_collect5 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            in_valid,
    input  logic [5*DATA_W-1:0]   in_data,
    output logic [4:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_src,
    input  logic                  out_ready
`ifdef COLLECT5_STATS_EN
    ,
    output logic [15:0]           stat_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + 3;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_last_grant;

    logic             w_grant_vld;
    logic [2:0]       w_grant_idx;
    logic [2:0]       w_cand;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    // Walk candidates from farthest to nearest so the nearest valid channel after last_grant wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 3'd0;
        w_cand      = 3'd0;
        if (!rst && r_count != FULL) begin
            for (int k = 5; k >= 1; k--) begin
                w_cand = wrap5(4'(r_last_grant) + 4'(k));
                if (in_valid[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    assign in_ready = w_grant_vld ? (5'b00001 << w_grant_idx) : 5'b00000;
    assign w_push   = w_grant_vld;
    assign w_pop    = out_valid && out_ready && !rst;

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_grant_idx, in_data[w_grant_idx*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= 3'd4;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = out_valid ? w_head[DATA_W-1:0] : '0;
    assign out_src   = out_valid ? w_head[DATA_W +: 3] : 3'd0;

`ifdef COLLECT5_STATS_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt <= 16'd0;
        end else if (w_pop) begin
            r_stat_cnt <= sat_inc16(r_stat_cnt);
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_subinst_collect5.sv
// Directed bench for subinst_collect5 with a queue-based reference model checked every cycle.
module tb_subinst_collect5;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_valid;
    logic [39:0] in_data;
    logic [4:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_src;
    logic        out_ready;
`ifdef COLLECT5_STATS_EN
    logic [15:0] stat_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    subinst_collect5 #(.DATA_W(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
`ifdef COLLECT5_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {src, data}, the last granted channel and a delivered count.
    logic [10:0] m_q[$];
    int          m_last = 4;
    logic [15:0] m_stat = 16'd0;

    always @(negedge clk) begin
        int g;
        int c;
        logic [4:0] exp_rdy;
        logic       exp_v;
        if (chk_en) begin
            g = -1;
            if (!rst && m_q.size() < 4) begin
                for (int k = 1; k <= 5; k++) begin
                    c = (m_last + k) % 5;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end
            exp_rdy = (g >= 0) ? 5'(1 << g) : 5'd0;
            exp_v   = (m_q.size() != 0);
            chk("model in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("model out_valid", 32'(out_valid), 32'(exp_v));
            chk("model out_data", 32'(out_data), exp_v ? 32'(m_q[0][7:0]) : 32'd0);
            chk("model out_src", 32'(out_src), exp_v ? 32'(m_q[0][10:8]) : 32'd0);
`ifdef COLLECT5_STATS_EN
            chk("model stat_cnt", 32'(stat_cnt), 32'(m_stat));
`endif
            if (rst) begin
                m_q.delete();
                m_last = 4;
                m_stat = 16'd0;
            end else begin
                if (exp_v && out_ready) begin
                    void'(m_q.pop_front());
                    if (m_stat != 16'hFFFF) m_stat = m_stat + 16'd1;
                end
                if (g >= 0) begin
                    m_q.push_back({3'(g), in_data[g*8 +: 8]});
                    m_last = g;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 5'd0;
        in_data   = 40'd0;
        out_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset then idle
        #1;
        chk("idle in_ready", 32'(in_ready), 32'd0);
        chk("idle out_valid", 32'(out_valid), 32'd0);
        chk("idle out_data", 32'(out_data), 32'd0);
        chk("idle out_src", 32'(out_src), 32'd0);
`ifdef COLLECT5_STATS_EN
        chk("idle stat_cnt", 32'(stat_cnt), 32'd0);
`endif
        step();

        // Single word from channel 2
        in_valid  = 5'b00100;
        in_data   = 40'd0;
        in_data[23:16] = 8'hA5;
        out_ready = 1'b1;
        #1;
        chk("single in_ready", 32'(in_ready), 32'h04);
        step();
        in_valid = 5'd0;
        #1;
        chk("single out_valid", 32'(out_valid), 32'd1);
        chk("single out_data", 32'(out_data), 32'hA5);
        chk("single out_src", 32'(out_src), 32'd2);
        step();
        #1;
        chk("single empty", 32'(out_valid), 32'd0);

        // Round-robin with all channels valid
        do_reset();
        in_data   = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        in_valid  = 5'b11111;
        out_ready = 1'b1;
        #1;
        chk("rr first grant", 32'(in_ready), 32'h01);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rr out_src", 32'(out_src), 32'(i % 5));
            chk("rr out_data", 32'(out_data), 32'(i % 5));
        end
        in_valid = 5'd0;
        step();
        step();

        // Full and backpressure on channel 1
        out_ready = 1'b0;
        in_valid  = 5'b00010;
        in_data   = 40'd0;
        for (int i = 0; i < 4; i++) begin
            in_data[15:8] = 8'(8'h10 + i);
            #1;
            chk("fill in_ready", 32'(in_ready), 32'h02);
            step();
        end
        in_data[15:8] = 8'h14;
        #1;
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full head", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        #1;
        chk("full pop no push", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        #1;
        chk("after pop in_ready", 32'(in_ready), 32'h02);
        chk("after pop head", 32'(out_data), 32'h11);
        step();
        in_valid  = 5'd0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain order", 32'(out_data), 32'(8'h10 + i));
            step();
        end
        chk("drain empty", 32'(out_valid), 32'd0);

        // Reset mid-stream with three words queued
        out_ready = 1'b0;
        in_valid  = 5'b00001;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11, 8'h77};
        for (int i = 0; i < 3; i++) step();
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        in_valid = 5'b01000;
        rst = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("post-reset valid", 32'(out_valid), 32'd0);
        in_valid = 5'b01001;
        #1;
        chk("post-reset grant", 32'(in_ready), 32'h01);
        step();
        in_valid  = 5'd0;
        out_ready = 1'b1;
        chk("post-reset src", 32'(out_src), 32'd0);
        chk("post-reset data", 32'(out_data), 32'h77);
        step();
        step();

`ifdef COLLECT5_STATS_EN
        // Delivered-word counter and saturation
        do_reset();
        out_ready = 1'b1;
        in_valid  = 5'b10000;
        for (int i = 0; i < 5; i++) step();
        in_valid = 5'd0;
        step();
        chk("stat five", 32'(stat_cnt), 32'd5);
        force dut.r_stat_cnt = 16'hFFFF;
        #1;
        release dut.r_stat_cnt;
        m_stat = 16'hFFFF;
        step();
        in_valid = 5'b00001;
        step();
        in_valid = 5'd0;
        step();
        chk("stat saturate", 32'(stat_cnt), 32'hFFFF);
        step();
`endif

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
